// File: rtl/data_path_loader_pkg.sv
// Shared types and widths for the host-side stream loader feeding data_path storages.
package data_path_loader_pkg;
    localparam int WORD_W        = 16;
    localparam int WORDS_PER_ROW = 3;
    localparam int ROW_W         = WORD_W * WORDS_PER_ROW;
    localparam int INDEX_W       = 32;
    localparam int CODE_W        = 12;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        TGT_INPUT  = 2'd0,
        TGT_WEIGHT = 2'd1,
        TGT_LABEL  = 2'd2,
        TGT_CODE   = 2'd3
    } target_e;

    typedef enum logic [2:0] {
        S_IDLE, S_BASE, S_COUNT, S_PAYLOAD, S_WRITE, S_CHECK, S_DONE
    } state_e;
endpackage

// File: rtl/data_path_loader_row_packer.sv
// Packs WORDS_PER_ROW stream words into one row, first word in the low slice.
module data_path_loader_row_packer
    import data_path_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_word,
    output logic [ROW_W-1:0]  o_row,
    output logic              o_last,
    output logic              o_full
);
    localparam int CW = $clog2(WORDS_PER_ROW + 1);

    logic [CW-1:0]    r_cnt;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_cnt <= '0;
            r_row <= '0;
        end else if (i_push && !o_full) begin
            r_row[int'(r_cnt)*WORD_W +: WORD_W] <= i_word;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // o_last flags that the word being pushed now completes the row
    assign o_last = (r_cnt == CW'(WORDS_PER_ROW - 1));
    assign o_full = (r_cnt == CW'(WORDS_PER_ROW));
    assign o_row  = r_row;
endmodule

// File: rtl/data_path_loader.sv
// Stream packet parser issuing row/line write pulses to data_path storages.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
module data_path_loader
    import data_path_loader_pkg::*;
(
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [INDEX_W-1:0] mat_write_layer,
    output logic [INDEX_W-1:0] mat_write_row,
    output logic [ROW_W-1:0]   mat_write_data,
    output logic               input_is_write,
    output logic               weight_is_write,
    output logic               label_is_write,
    output logic [INDEX_W-1:0] code_write_line,
    output logic [CODE_W-1:0]  code_write_data,
    output logic               code_is_write,
    output logic               busy,
    output logic               done,
    output logic               err
);
`ifdef LOADER_CHECKSUM_EN
    localparam state_e S_END = S_CHECK;
`else
    localparam state_e S_END = S_DONE;
`endif

    state_e             r_state, w_next;
    target_e            r_tgt;
    logic [INDEX_W-1:0] r_base;
    logic [CNT_W-1:0]   r_count, r_row;
    logic               r_live;
    logic               w_xfer, w_last_row, w_wr;
    logic               w_pk_last, w_pk_full;
    logic [ROW_W-1:0]   w_row;

    assign w_xfer     = s_valid & s_ready;
    assign w_last_row = (r_row == r_count - 1'b1);
    assign w_wr       = (r_state == S_WRITE);

    data_path_loader_row_packer u_packer (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_clear (w_wr),
        .i_push  (w_xfer && r_state == S_PAYLOAD),
        .i_word  (s_data),
        .o_row   (w_row),
        .o_last  (w_pk_last),
        .o_full  (w_pk_full)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_tgt   <= TGT_INPUT;
            r_base  <= '0;
            r_count <= '0;
            r_row   <= '0;
        end else begin
            if (r_state == S_IDLE && w_xfer)  r_tgt  <= target_e'(s_data[1:0]);
            if (r_state == S_BASE && w_xfer)  r_base <= INDEX_W'(s_data);
            if (r_state == S_COUNT && w_xfer) begin
                r_count <= s_data;
                r_row   <= '0;
            end
            if (w_wr && !w_last_row) r_row <= r_row + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_xfer) w_next = S_BASE;
            S_BASE:    if (w_xfer) w_next = S_COUNT;
            S_COUNT:   if (w_xfer) w_next = (s_data == '0) ? S_END : S_PAYLOAD;
            // code lines are a single word; matrix rows wait for the packer
            S_PAYLOAD: if (w_xfer && (r_tgt == TGT_CODE || w_pk_last)) w_next = S_WRITE;
            S_WRITE:   w_next = w_last_row ? S_END : S_PAYLOAD;
            S_CHECK:   if (w_xfer) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign s_ready = r_live && (r_state == S_IDLE || r_state == S_BASE || r_state == S_COUNT ||
                                r_state == S_PAYLOAD || r_state == S_CHECK);
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);

    assign input_is_write  = w_wr && w_pk_full && r_tgt == TGT_INPUT;
    assign weight_is_write = w_wr && w_pk_full && r_tgt == TGT_WEIGHT;
    assign label_is_write  = w_wr && w_pk_full && r_tgt == TGT_LABEL;
    assign code_is_write   = w_wr && r_tgt == TGT_CODE;

    assign mat_write_layer = r_base;
    assign mat_write_row   = INDEX_W'(r_row);
    assign mat_write_data  = w_row;
    assign code_write_line = r_base + INDEX_W'(r_row);
    assign code_write_data = w_row[CODE_W-1:0];

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;
    logic              r_err;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else if (w_xfer) begin
            case (r_state)
                S_IDLE: begin
                    r_sum <= s_data;
                    r_err <= 1'b0;
                end
                S_CHECK: r_err <= (s_data != r_sum);
                default: r_sum <= r_sum + s_data;
            endcase
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_data_path_loader.sv
// Self-checking bench for data_path_loader: directed spec scenarios plus random packets.
module tb_data_path_loader;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] mat_write_layer, mat_write_row, code_write_line;
    logic [47:0] mat_write_data;
    logic [11:0] code_write_data;
    logic        input_is_write, weight_is_write, label_is_write, code_is_write;
    logic        busy, done, err;

    always #5 clk_clk = ~clk_clk;

    data_path_loader dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .mat_write_layer(mat_write_layer), .mat_write_row(mat_write_row),
        .mat_write_data(mat_write_data), .input_is_write(input_is_write),
        .weight_is_write(weight_is_write), .label_is_write(label_is_write),
        .code_write_line(code_write_line), .code_write_data(code_write_data),
        .code_is_write(code_is_write), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [47:0] d;
    } wr_t;

    wr_t         exp_q[$], obs_q[$];
    logic [15:0] pay_q[$];
    int          n_checks = 0, n_fail = 0;
    int          done_cnt = 0, ready_err = 0, multi_err = 0;
    bit          mon_en = 1'b0;

    // Observes every write pulse and the handshake rules each cycle
    always @(negedge clk_clk) begin : mon
        int  nw;
        wr_t e;
        nw = int'(input_is_write) + int'(weight_is_write) + int'(label_is_write) + int'(code_is_write);
        if (mon_en) begin
            if (nw > 1) multi_err++;
            if ((nw != 0 && s_ready) || (nw == 0 && !done && !s_ready)) ready_err++;
            e = {2'd0, mat_write_layer, mat_write_row, mat_write_data};
            if (input_is_write)  begin e.kind = 2'd0; obs_q.push_back(e); end
            if (weight_is_write) begin e.kind = 2'd1; obs_q.push_back(e); end
            if (label_is_write)  begin e.kind = 2'd2; obs_q.push_back(e); end
            if (code_is_write)   obs_q.push_back({2'd3, code_write_line, 32'd0, 36'd0, code_write_data});
            if (done) done_cnt++;
        end
    end

    task automatic send_word(input logic [15:0] w, input bit gap);
        int t = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (s_ready !== 1'b1 && t < 100) begin
            @(negedge clk_clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send_word_timeout: s_ready=%b after %0d cycles, required 1", s_ready, t);
        end
        @(negedge clk_clk);
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        if (gap) @(negedge clk_clk);
    endtask

    // Reference model: expected writes come straight from the packet layout rules
    task automatic send_packet(input logic [15:0] h0, input logic [15:0] base, input logic [15:0] n,
                               input bit gap, input bit bad);
        logic [15:0] sum;
        wr_t         e;
        int          d0, t;
        for (int r = 0; r < int'(n); r++) begin
            if (h0[1:0] == 2'd3)
                e = {2'd3, 32'(base) + 32'(r), 32'd0, 36'd0, pay_q[r][11:0]};
            else
                e = {h0[1:0], 32'(base), 32'(r), pay_q[3*r+2], pay_q[3*r+1], pay_q[3*r]};
            exp_q.push_back(e);
        end
        sum = h0 + base + n;
        foreach (pay_q[i]) sum = sum + pay_q[i];
        if (bad) sum = ~sum;
        d0 = done_cnt;
        send_word(h0, gap);
        send_word(base, gap);
        send_word(n, gap);
        foreach (pay_q[i]) send_word(pay_q[i], gap);
`ifdef LOADER_CHECKSUM_EN
        send_word(sum, gap);
`endif
        t = 0;
        while (done_cnt == d0 && t < 50) begin
            @(negedge clk_clk); #1;
            t++;
        end
        if (done_cnt == d0) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", t);
        end
        repeat (2) @(negedge clk_clk);
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk_clk);
        n_checks++;
        if ({s_ready, busy, done, err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: ready/busy/done/err=%b required 0000", {s_ready, busy, done, err});
        end
        n_checks++;
        if ({input_is_write, weight_is_write, label_is_write, code_is_write} !== 4'b0) begin
            n_fail++; $display("FAIL reset_writes: got %b required 0000",
                               {input_is_write, weight_is_write, label_is_write, code_is_write});
        end
        n_checks++;
        if (mat_write_data !== 48'd0 || mat_write_layer !== 32'd0 || code_write_line !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: data=%h layer=%h line=%h required 0",
                               mat_write_data, mat_write_layer, code_write_line);
        end
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: s_ready=%b busy=%b required 1/0", s_ready, busy);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_weight();
        wr_t         e;
        int          d0, t;
        logic [15:0] sum;
        d0 = done_cnt;
        sum = 16'd26;
        exp_q.push_back({2'd1, 32'd2, 32'd0, 48'h0003_0002_0001});
        exp_q.push_back({2'd1, 32'd2, 32'd1, 48'h0006_0005_0004});
        send_word(16'd1, 0); send_word(16'd2, 0); send_word(16'd2, 0);
        for (int i = 1; i <= 6; i++) begin
            send_word(16'(i), 0);
            n_checks++;
            if (weight_is_write !== ((i % 3) == 0)) begin
                n_fail++; $display("FAIL weight_timing[%0d]: weight_is_write=%b required %b", i, weight_is_write, (i % 3) == 0);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(sum, 0);
`endif
        t = 0;
        while (done_cnt == d0 && t < 50) begin @(negedge clk_clk); #1; t++; end
        repeat (4) @(negedge clk_clk);
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL weight_done: %0d done pulses, required 1", done_cnt - d0);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL weight_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL weight_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
        if (sum == 16'd0) e = '0;
    endtask

    task automatic test_code();
        pay_q = '{16'hFABC, 16'h0123};
        send_packet(16'd3, 16'hFFFF, 16'd2, 0, 0);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL code_count: got %0d writes, required 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== {2'd3, 32'h0000_FFFF, 32'd0, 48'h000000000ABC}) begin
                n_fail++; $display("FAIL code_line0: got %h required line FFFF data ABC", obs_q[0]);
            end
            n_checks++;
            if (obs_q[1] !== {2'd3, 32'h0001_0000, 32'd0, 48'h000000000123}) begin
                n_fail++; $display("FAIL code_line1: got %h required line 10000 data 123", obs_q[1]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_gaps();
        int r0;
        r0 = ready_err;
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(16'($urandom));
        send_packet(16'h0000, 16'($urandom), 16'd3, 1, 0);
        n_checks++;
        if (ready_err != r0 || multi_err != 0) begin
            n_fail++; $display("FAIL gaps_handshake: ready_err=%0d multi_err=%0d required %0d/0", ready_err, multi_err, r0);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL gaps_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL gaps_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_zero_count();
        logic [15:0] h1;
        h1 = 16'($urandom);
        send_word(16'd2, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_busy_h0: busy=%b required 1", busy);
        end
        send_word(h1, 0);
        send_word(16'd0, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(16'd2 + h1, 0);
`endif
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_done: done=%b busy=%b required 1/1", done, busy);
        end
        @(negedge clk_clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_idle: done=%b busy=%b required 0/0", done, busy);
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL zero_writes: got %0d writes, required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        send_word(16'd0, 0); send_word(16'd5, 0); send_word(16'd2, 0);
        send_word(16'hAAAA, 0); send_word(16'hBBBB, 0);
        mon_en = 1'b0;
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        mon_en = 1'b1;
        n_checks++;
        if (obs_q.size() != 0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_state: writes=%0d busy=%b s_ready=%b required 0/0/1", obs_q.size(), busy, s_ready);
        end
        pay_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        send_packet(16'h0004, 16'd7, 16'd2, 0, 0);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL midreset_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL midreset_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pay_q = '{16'h0ABC};
        send_packet(16'h0003, 16'h0010, 16'd1, 0, 1);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL csum_bad: err=%b required 1", err);
        end
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL csum_bad_writes: got %0d writes, required 1", obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
        send_word(16'h0001, 0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL csum_clear_on_h0: err=%b required 0", err);
        end
        send_word(16'd0, 0); send_word(16'd0, 0); send_word(16'h0001, 0);
        repeat (3) @(negedge clk_clk);
        pay_q = '{16'hFFFF, 16'hFFFF, 16'h8000};
        send_packet(16'hFFF2, 16'hFFFF, 16'd1, 0, 0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL csum_good: err=%b required 0", err);
        end
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    task automatic test_random();
        logic [31:0] rnd;
        int          n;
        for (int p = 0; p < 8; p++) begin
            rnd = $urandom;
            n   = int'($urandom_range(1, 3));
            pay_q.delete();
            for (int i = 0; i < ((rnd[1:0] == 2'd3) ? n : 3 * n); i++) pay_q.push_back(16'($urandom));
            send_packet({rnd[15:2], rnd[1:0]}, rnd[31:16], 16'(n), rnd[2], 0);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL random_count[%0d]: got %0d writes, required %0d", p, obs_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL random_write[%0d.%0d]: got %h required %h", p, i, obs_q[i], exp_q[i]);
                end
            end
            obs_q.delete(); exp_q.delete();
        end
        n_checks++;
        if (multi_err != 0 || ready_err != 0) begin
            n_fail++; $display("FAIL random_handshake: multi_err=%0d ready_err=%0d required 0/0", multi_err, ready_err);
        end
    endtask

    initial begin
        test_reset();
        test_weight();
        test_code();
        test_gaps();
        test_zero_count();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
